// File: rtl/com_uart_pkg.sv
// rtl/com_uart_pkg.sv - shared state encodings, bit-period helper and RX FIFO depth for com_uart
package com_uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  localparam int RX_FIFO_DEPTH = 4;

  // Bit period in clocks, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/com_uart_rx_fifo.sv
// rtl/com_uart_rx_fifo.sv - 4-entry receive byte FIFO, built only under COM_UART_RX_FIFO_EN
module com_uart_rx_fifo
  import com_uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       empty,
  output logic       full
);

  localparam int PW = $clog2(RX_FIFO_DEPTH);
  localparam logic [PW:0] COUNT_FULL = (PW + 1)'(RX_FIFO_DEPTH);

  logic [7:0]    mem [RX_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == COUNT_FULL);
  assign do_pop   = pop & ~empty;
  // A full FIFO still takes a push when the same cycle frees a slot.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RX_FIFO_DEPTH; i++) mem[i] <= 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/com_uart.sv
// rtl/com_uart.sv - 8N1 UART for the memory controller serial path
// COM_UART_RX_FIFO_EN selects a 4-entry receive FIFO instead of a single holding register.
module com_uart
  import com_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic [7:0] com_data_out,
  input  logic       enable_com_write,
  output logic       com_write_ready,
  output logic [7:0] com_data_in,
  output logic       com_read_ready,
  input  logic       int_com_ack,
  output logic       uart_txd,
  input  logic       uart_rxd
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  // ---------------- transmitter ----------------
  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_idx, tx_idx_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          txd_q, txd_n;

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= 8'h00;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      txd_q    <= txd_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    txd_n      = txd_q;
    case (tx_state)
      TX_IDLE: begin
        if (enable_com_write) begin
          tx_shift_n = com_data_out;
          txd_n      = 1'b0;
          tx_cnt_n   = '0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n   = '0;
          tx_idx_n   = 3'd0;
          txd_n      = tx_shift[0];
          tx_state_n = TX_DATA;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          if (tx_idx == 3'd7) begin
            txd_n      = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            tx_idx_n = tx_idx + 3'd1;
            txd_n    = tx_shift[tx_idx + 3'd1];
          end
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_IDLE;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign uart_txd        = txd_q;
  assign com_write_ready = (tx_state == TX_IDLE);

  // ---------------- receiver ----------------
  logic [1:0]    rx_sync;
  logic          rxs;
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bits, rx_bits_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_push;
  logic          ack_q, ack_q2;
  logic          ack_rise;

  assign rxs      = rx_sync[1];
  assign ack_rise = ack_q & ~ack_q2;

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= 8'h00;
      ack_q    <= 1'b0;
      ack_q2   <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], uart_rxd};
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bits  <= rx_bits_n;
      rx_shift <= rx_shift_n;
      ack_q    <= int_com_ack;
      ack_q2   <= ack_q;
    end
  end

  // Start bit is re-checked half a bit in, so later samples fall mid-bit.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bits_n  = rx_bits;
    rx_shift_n = rx_shift;
    rx_push    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rxs) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bits_n  = 3'd0;
          rx_state_n = rxs ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rxs, rx_shift[7:1]};
          if (rx_bits == 3'd7) rx_state_n = RX_STOP;
          else                 rx_bits_n  = rx_bits + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n = '0;
          if (rxs) begin
            rx_push    = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n = RX_BREAK;
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_BREAK: begin
        if (rxs) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- receive storage ----------------
`ifdef COM_UART_RX_FIFO_EN
  logic fifo_empty;
  logic fifo_full;

  com_uart_rx_fifo u_rx_fifo (
    .clk       (clk50M),
    .rst_n     (rst_n),
    .push      (rx_push & (~fifo_full | ack_rise)),
    .push_data (rx_shift),
    .pop       (ack_rise),
    .pop_data  (com_data_in),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign com_read_ready = ~fifo_empty;
`else
  logic       hold_valid;
  logic [7:0] hold_data;
  logic       hold_pop;

  assign hold_pop = ack_rise & hold_valid;

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= 8'h00;
    end else if (rx_push && (!hold_valid || hold_pop)) begin
      hold_valid <= 1'b1;
      hold_data  <= rx_shift;
    end else if (hold_pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign com_read_ready = hold_valid;
  assign com_data_in    = hold_data;
`endif

endmodule

// File: tb/tb_com_uart.sv
// tb/tb_com_uart.sv - self-checking bench for com_uart at DIV = 10 (COM_UART_RX_FIFO_EN aware)
module tb_com_uart;

`ifdef COM_UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk50M = 1'b0;
  logic       rst_n;
  logic [7:0] com_data_out;
  logic       enable_com_write;
  logic       com_write_ready;
  logic [7:0] com_data_in;
  logic       com_read_ready;
  logic       int_com_ack;
  logic       uart_txd;
  logic       uart_rxd;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] rxq[$];

  com_uart #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
    .clk50M           (clk50M),
    .rst_n            (rst_n),
    .com_data_out     (com_data_out),
    .enable_com_write (enable_com_write),
    .com_write_ready  (com_write_ready),
    .com_data_in      (com_data_in),
    .com_read_ready   (com_read_ready),
    .int_com_ack      (int_com_ack),
    .uart_txd         (uart_txd),
    .uart_rxd         (uart_rxd)
  );

  always #5 clk50M = ~clk50M;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for slot 0..9 of an 8N1 frame.
  function automatic logic frame_bit(input logic [7:0] b, input int slot, input logic stop);
    if (slot == 0) return 1'b0;
    if (slot == 9) return stop;
    return 1'(int'(b) >> (slot - 1));
  endfunction

  // Transmit b; optionally inject a second request at cycle inj_at or reset at cycle rst_at.
  task automatic tx_frame(input logic [7:0] b, input int inj_at, input logic [7:0] inj, input int rst_at);
    int low_cnt = 0;
    @(negedge clk50M);
    com_data_out     = b;
    enable_com_write = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk50M);
      if (k == 1) enable_com_write = 1'b0;
      check("tx_line", uart_txd, frame_bit(b, (k - 1) / 10, 1'b1));
      if (!com_write_ready) low_cnt++;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_txd", uart_txd, 1'b1);
        check("rst_wready", com_write_ready, 1'b1);
        check("rst_rready", com_read_ready, 1'b0);
        check("rst_rdata", com_data_in, 8'h00);
        @(negedge clk50M);
        rst_n = 1'b1;
        @(negedge clk50M);
        return;
      end
      if (k == inj_at) begin
        com_data_out     = inj;
        enable_com_write = 1'b1;
      end
      if (k == inj_at + 1) enable_com_write = 1'b0;
    end
    @(negedge clk50M);
    check("tx_ready_low_cycles", low_cnt, 100);
    check("tx_ready_after", com_write_ready, 1'b1);
    check("tx_idle_line", uart_txd, 1'b1);
  endtask

  task automatic check_rx_state(input string tag);
    check({tag, "_ready"}, com_read_ready, (rxq.size() != 0));
    if (rxq.size() != 0) check({tag, "_data"}, com_data_in, rxq[0]);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    for (int slot = 0; slot < 10; slot++) begin
      @(negedge clk50M);
      uart_rxd = frame_bit(b, slot, stop);
      repeat (9) @(negedge clk50M);
    end
    @(negedge clk50M);
    uart_rxd = 1'b1;
    repeat (6) @(negedge clk50M);
    if (stop && rxq.size() < CAP) rxq.push_back(b);
    check_rx_state("rx");
  endtask

  task automatic ack(input int len);
    @(negedge clk50M);
    int_com_ack = 1'b1;
    repeat (len) @(negedge clk50M);
    int_com_ack = 1'b0;
    repeat (4) @(negedge clk50M);
    if (rxq.size() != 0) void'(rxq.pop_front());
    check_rx_state("pop");
  endtask

  initial begin
    logic [7:0] r;
    rst_n            = 1'b0;
    uart_rxd         = 1'b1;
    enable_com_write = 1'b0;
    com_data_out     = 8'h00;
    int_com_ack      = 1'b0;
    repeat (3) @(negedge clk50M);
    check("reset_txd", uart_txd, 1'b1);
    check("reset_wready", com_write_ready, 1'b1);
    check("reset_rready", com_read_ready, 1'b0);
    check("reset_rdata", com_data_in, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk50M);

    tx_frame(8'hA5, -10, 8'h00, -1);
    tx_frame(8'h3C, 50, 8'hFF, -1);
    repeat (3) @(negedge clk50M);
    check("busy_drop_idle", uart_txd, 1'b1);
    check("busy_drop_ready", com_write_ready, 1'b1);

    rx_frame(8'h5A, 1'b1);
    ack(5);

    @(negedge clk50M);
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk50M);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk50M);
    check_rx_state("glitch");

    rx_frame(8'h11, 1'b0);
    rx_frame(8'h22, 1'b1);
    ack(1);

    for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b1);
    while (rxq.size() != 0) ack(1);

    tx_frame(8'hC3, -10, 8'h00, 35);
    tx_frame(8'h80, -10, 8'h00, -1);

    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom);
      tx_frame(r, -10, 8'h00, -1);
    end
    for (int i = 0; i < 6; i++) begin
      r = 8'($urandom);
      rx_frame(r, ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 1) == 1) ack($urandom_range(1, 6));
    end
    while (rxq.size() != 0) ack($urandom_range(1, 6));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
